// File: rtl/coin_counter.sv
// Vending-machine coin accumulator: edge-detects quarter/dime/nickel sense lines and keeps a saturating 10-bit cent total.
// Optional COIN_COUNTER_SYNC_EN adds a 2-flop synchronizer on each coin line for asynchronous sensors.
module coin_counter (
    input  logic       clk,
    input  logic       resetCount,
    input  logic       inQuarter,
    input  logic       inDime,
    input  logic       inNickel,
    output logic [9:0] outCount
);

    logic [2:0]  coin_raw_s;
    logic [2:0]  coin_s;
    logic [2:0]  prev_r;
    logic [2:0]  edge_s;
    logic [6:0]  inc_s;
    logic [10:0] sum_s;
    logic [9:0]  next_s;
    logic [9:0]  count_r;

    // Bit order {quarter, dime, nickel}.
    assign coin_raw_s = {inQuarter, inDime, inNickel};

`ifdef COIN_COUNTER_SYNC_EN
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;

    // Two-stage synchronizer for asynchronous sensor lines.
    always_ff @(posedge clk) begin
        if (resetCount) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= coin_raw_s;
            sync2_r <= sync1_r;
        end
    end

    assign coin_s = sync2_r;
`else
    assign coin_s = coin_raw_s;
`endif

    // Previous-level register; also loads on reset so a line high at release is ignored.
    always_ff @(posedge clk) begin
        prev_r <= coin_s;
    end

    assign edge_s = coin_s & ~prev_r;

    // Sum simultaneous events, then saturate at the 10-bit ceiling.
    always_comb begin
        inc_s  = 7'd0;
        sum_s  = 11'd0;
        next_s = count_r;
        if (edge_s[2]) begin
            inc_s = inc_s + 7'd25;
        end else begin
            inc_s = inc_s;
        end
        if (edge_s[1]) begin
            inc_s = inc_s + 7'd10;
        end else begin
            inc_s = inc_s;
        end
        if (edge_s[0]) begin
            inc_s = inc_s + 7'd5;
        end else begin
            inc_s = inc_s;
        end
        sum_s = {1'b0, count_r} + {4'b0000, inc_s};
        if (sum_s > 11'd1023) begin
            next_s = 10'd1023;
        end else begin
            next_s = sum_s[9:0];
        end
    end

    // Running total register; reset discards any same-cycle coin edge.
    always_ff @(posedge clk) begin
        if (resetCount) begin
            count_r <= 10'd0;
        end else begin
            count_r <= next_s;
        end
    end

    assign outCount = count_r;

endmodule

// File: tb/tb_coin_counter.sv
// Scoreboard bench for coin_counter: stimulus pushes the hand-computed total expected after each clk edge,
// a monitor pops and compares one entry per edge.
module tb_coin_counter;

    logic       clk;
    logic       resetCount;
    logic       inQuarter;
    logic       inDime;
    logic       inNickel;
    logic [9:0] outCount;

    typedef struct {
        string      name;
        logic [9:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    bit   stim_done;

    coin_counter dut (
        .clk        (clk),
        .resetCount (resetCount),
        .inQuarter  (inQuarter),
        .inDime     (inDime),
        .inNickel   (inNickel),
        .outCount   (outCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and record the total expected after the next edge.
    task automatic cyc(input bit r, input bit q, input bit d, input bit n,
                       input int expv, input string name);
        exp_t e;
        @(posedge clk);
        #2;
        resetCount = r;
        inQuarter  = q;
        inDime     = d;
        inNickel   = n;
        e.name  = name;
        e.value = expv[9:0];
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry is consumed per clk edge, sampled 1 ns after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (outCount !== e.value) begin
                    n_fail++;
                    $display("FAIL %s: outCount=%0d expected=%0d at %0t", e.name, outCount, e.value, $time);
                end
            end
        end
    end

    initial begin
        int e;
        n_tests    = 0;
        n_fail     = 0;
        stim_done  = 1'b0;
        resetCount = 1'b1;
        inQuarter  = 1'b0;
        inDime     = 1'b0;
        inNickel   = 1'b0;

`ifdef COIN_COUNTER_SYNC_EN
        cyc(1, 0, 0, 0, 0, "sync_reset");
        cyc(1, 0, 0, 0, 0, "sync_reset");
        cyc(0, 0, 0, 0, 0, "sync_idle");
        cyc(0, 0, 0, 1, 0, "sync_nickel_e1");
        cyc(0, 0, 0, 1, 0, "sync_nickel_e2");
        cyc(0, 0, 0, 1, 5, "sync_nickel_e3");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 5, "sync_nickel_once");
`else
        // Reset and idle
        cyc(1, 0, 0, 0, 0, "reset");
        cyc(1, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, "idle");

        // Single coins, each held 2 cycles
        cyc(0, 1, 0, 0, 25, "quarter");
        cyc(0, 1, 0, 0, 25, "quarter_held");
        cyc(0, 0, 0, 0, 25, "quarter_low");
        cyc(0, 0, 1, 0, 35, "dime");
        cyc(0, 0, 1, 0, 35, "dime_held");
        cyc(0, 0, 0, 0, 35, "dime_low");
        cyc(0, 0, 0, 1, 40, "nickel");
        cyc(0, 0, 0, 1, 40, "nickel_held");
        cyc(0, 0, 0, 0, 40, "nickel_low");

        // Simultaneous Q+D+N
        cyc(1, 0, 0, 0, 0, "clear");
        cyc(0, 1, 1, 1, 40, "all_three");
        cyc(0, 0, 0, 0, 40, "all_three_low");

        // Saturation: 41 quarters then a nickel
        cyc(1, 0, 0, 0, 0, "clear");
        for (int i = 1; i <= 41; i++) begin
            e = (25 * i > 1023) ? 1023 : 25 * i;
            cyc(0, 1, 0, 0, e, "sat_quarter");
            cyc(0, 0, 0, 0, e, "sat_quarter_low");
        end
        cyc(0, 0, 0, 1, 1023, "sat_nickel");
        cyc(0, 0, 0, 0, 1023, "sat_hold");

        // Reset edge cases
        cyc(1, 1, 0, 0, 0, "quarter_with_reset");
        cyc(0, 1, 0, 0, 0, "quarter_held_over_release");
        cyc(0, 0, 0, 0, 0, "after_release");
        cyc(0, 0, 1, 0, 10, "dime_after_reset");
        cyc(0, 1, 0, 1, 40, "quarter_nickel");
        cyc(0, 0, 0, 0, 40, "final_hold");
`endif

        // Drain: allow the monitor to consume the last entry, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
